// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad debouncer slice.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE_DB
    } state_t;

    localparam int unsigned DEF_ID_W = 5;

    // Enough bits to hold max_val itself, so "cnt + 1 == max_val" never wraps.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/keypad_debouncer_repeat_timer.sv
// Typematic schedule: first tick after REPEAT_DLY run cycles, then every REPEAT_PER.
module repeat_timer
    import keypad_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = 8,
    parameter int unsigned REPEAT_PER = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned MAX_V = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RW    = cnt_w(MAX_V);
    localparam logic [RW-1:0] DLY_V = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] PER_V = RW'(REPEAT_PER);
    localparam logic [RW-1:0] ONE   = RW'(1);

    logic [RW-1:0] cnt;
    logic [RW-1:0] cnt_inc;
    logic [RW-1:0] target;
    logic          repeating;

    always_comb begin
        cnt_inc = cnt + ONE;
        target  = repeating ? PER_V : DLY_V;
        tick    = run && (cnt_inc == target);
    end

    // After the first tick the counter becomes a modulo-REPEAT_PER phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            repeating <= 1'b0;
        end else if (clear) begin
            cnt       <= '0;
            repeating <= 1'b0;
        end else if (run) begin
            if (tick) begin
                cnt       <= '0;
                repeating <= 1'b1;
            end else if (cnt_inc < target) begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/keypad_debouncer.sv
// Qualifies a raw scanned-keypad stream into press, held, repeat and release events.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned ID_W       = DEF_ID_W,
    parameter int unsigned STABLE_CYC = 3,
    parameter int unsigned REPEAT_DLY = 0,
    parameter int unsigned REPEAT_PER = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_pressed,
    input  logic [ID_W-1:0] key_id,
    output logic            key_valid,
    output logic [ID_W-1:0] key_code,
    output logic            key_held,
    output logic            key_release
);

    localparam int unsigned CW = cnt_w(STABLE_CYC);
    localparam logic [CW-1:0] STABLE_V = CW'(STABLE_CYC);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic [ID_W-1:0] id_lat, id_n, code_n;
    logic            valid_n, held_n, release_n;
    logic            match, accept, do_release;
    logic            rpt_run, rpt_tick;

    assign match   = key_pressed && (key_id == id_lat);
    assign cnt_inc = cnt + ONE;
    assign rpt_run = (state == HELD) && match;

    generate
        if (REPEAT_DLY > 0) begin : g_rpt
            repeat_timer #(
                .REPEAT_DLY(REPEAT_DLY),
                .REPEAT_PER(REPEAT_PER)
            ) u_repeat_timer (
                .clk  (clk),
                .rst  (rst),
                .run  (rpt_run),
                .clear(accept),
                .tick (rpt_tick)
            );
        end else begin : g_no_rpt
            assign rpt_tick = 1'b0;
        end
    endgenerate

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        id_n       = id_lat;
        code_n     = key_code;
        held_n     = key_held;
        valid_n    = 1'b0;
        release_n  = 1'b0;
        accept     = 1'b0;
        do_release = 1'b0;

        case (state)
            IDLE: begin
                if (key_pressed) begin
                    id_n  = key_id;
                    cnt_n = ONE;
                    if (STABLE_CYC == 1) begin
                        accept = 1'b1;
                        code_n = key_id;
                    end else begin
                        state_n = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (match) begin
                    if (cnt_inc == STABLE_V) begin
                        accept = 1'b1;
                        code_n = id_lat;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else if (key_pressed) begin
                    id_n  = key_id;
                    cnt_n = ONE;
                end else begin
                    state_n = IDLE;
                end
            end
            HELD: begin
                if (match) begin
                    valid_n = rpt_run & rpt_tick;
                end else if (STABLE_CYC == 1) begin
                    do_release = 1'b1;
                end else begin
                    cnt_n   = ONE;
                    state_n = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                // Returning to HELD does not advance the repeat schedule on this edge.
                if (match) begin
                    state_n = HELD;
                end else if (cnt_inc == STABLE_V) begin
                    do_release = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: state_n = IDLE;
        endcase

        if (accept) begin
            valid_n = 1'b1;
            held_n  = 1'b1;
            state_n = HELD;
        end
        if (do_release) begin
            release_n = 1'b1;
            held_n    = 1'b0;
            state_n   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            id_lat      <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            id_lat      <= id_n;
            key_code    <= code_n;
            key_valid   <= valid_n;
            key_held    <= held_n;
            key_release <= release_n;
        end
    end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Scoreboard bench: expected press/repeat/release events are queued with the edge that causes them.
module tb_keypad_debouncer;

    typedef struct {
        int unsigned at;
        logic        rel;
        logic [4:0]  code;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       kp_a, kp_b;
    logic [4:0] id_a, id_b;
    logic       valid_a, held_a, release_a;
    logic       valid_b, held_b, release_b;
    logic [4:0] code_a, code_b;

    ev_t         qa[$];
    ev_t         qb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned sample_edge = 0;

    always #5 clk = ~clk;

    keypad_debouncer #(
        .ID_W(5), .STABLE_CYC(3), .REPEAT_DLY(8), .REPEAT_PER(4)
    ) dut_a (
        .clk(clk), .rst(rst), .key_pressed(kp_a), .key_id(id_a),
        .key_valid(valid_a), .key_code(code_a), .key_held(held_a), .key_release(release_a)
    );

    keypad_debouncer #(
        .ID_W(5), .STABLE_CYC(1), .REPEAT_DLY(0), .REPEAT_PER(4)
    ) dut_b (
        .clk(clk), .rst(rst), .key_pressed(kp_b), .key_id(id_b),
        .key_valid(valid_b), .key_code(code_b), .key_held(held_b), .key_release(release_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (edge %0d)", tag, got, want, sample_edge);
        end
    endtask

    task automatic expect_ev(input bit on_b, input int unsigned at, input logic rel, input logic [4:0] code);
        ev_t e;
        e.at   = at;
        e.rel  = rel;
        e.code = code;
        if (on_b) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    task automatic step_a(input logic p, input logic [4:0] id);
        kp_a = p; id_a = id; kp_b = 1'b0; id_b = '0;
        @(posedge clk);
        sample_edge++;
        #1;
    endtask

    task automatic step_b(input logic p, input logic [4:0] id);
        kp_b = p; id_b = id; kp_a = 1'b0; id_a = '0;
        @(posedge clk);
        sample_edge++;
        #1;
    endtask

    task automatic hold_a(input logic p, input logic [4:0] id, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step_a(p, id);
    endtask

    task automatic hold_b(input logic p, input logic [4:0] id, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step_b(p, id);
    endtask

    always @(negedge clk) begin
        ev_t ea;
        if (!rst && (valid_a || release_a)) begin
            check("a_excl", 32'(valid_a & release_a), 0);
            check("a_pending", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check("a_at", sample_edge, ea.at);
                check("a_rel", 32'(release_a), 32'(ea.rel));
                check("a_code", 32'(code_a), 32'(ea.code));
            end
        end
    end

    always @(negedge clk) begin
        ev_t eb;
        if (!rst && (valid_b || release_b)) begin
            check("b_excl", 32'(valid_b & release_b), 0);
            check("b_pending", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check("b_at", sample_edge, eb.at);
                check("b_rel", 32'(release_b), 32'(eb.rel));
                check("b_code", 32'(code_b), 32'(eb.code));
            end
        end
    end

    initial begin
        int unsigned e0;
        int unsigned rep_w[6];

        rst = 1'b1;
        kp_a = 1'b0; id_a = '0; kp_b = 1'b0; id_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_a", 32'(valid_a), 0);
        check("rst_held_a", 32'(held_a), 0);
        check("rst_release_a", 32'(release_a), 0);
        check("rst_code_a", 32'(code_a), 0);
        check("rst_valid_b", 32'(valid_b), 0);
        check("rst_held_b", 32'(held_b), 0);
        check("rst_release_b", 32'(release_b), 0);
        check("rst_code_b", 32'(code_b), 0);
        @(negedge clk);
        rst = 1'b0;
        hold_a(0, 0, 2);

        // Clean press of 5, then release.
        e0 = sample_edge;
        expect_ev(0, e0 + 3, 0, 5);
        expect_ev(0, e0 + 6, 1, 5);
        hold_a(1, 5, 3);
        check("t1_held", 32'(held_a), 1);
        check("t1_code", 32'(code_a), 5);
        hold_a(0, 0, 2);
        check("t1_held_mid_rel", 32'(held_a), 1);
        step_a(0, 0);
        check("t1_held_after", 32'(held_a), 0);
        hold_a(0, 0, 2);

        // Bounce: two samples, a drop, then three good samples.
        e0 = sample_edge;
        expect_ev(0, e0 + 6, 0, 5);
        expect_ev(0, e0 + 9, 1, 5);
        hold_a(1, 5, 2);
        step_a(0, 0);
        hold_a(1, 5, 2);
        check("t2_not_yet", 32'(held_a), 0);
        step_a(1, 5);
        check("t2_held", 32'(held_a), 1);
        hold_a(0, 0, 3);
        hold_a(0, 0, 2);

        // Id switch 2 -> 9: only 9 is accepted.
        e0 = sample_edge;
        expect_ev(0, e0 + 5, 0, 9);
        expect_ev(0, e0 + 8, 1, 9);
        hold_a(1, 2, 2);
        hold_a(1, 9, 3);
        check("t3_code", 32'(code_a), 9);
        hold_a(0, 0, 3);
        check("t3_code_kept", 32'(code_a), 9);
        hold_a(0, 0, 2);

        // Long hold with a 2-sample glitch at held cycles 14-15. The glitch plus the
        // edge that returns to HELD do not advance the schedule: matches 16/20/24/28
        // land on wall cycles 19/23/27/31.
        rep_w = '{8, 12, 19, 23, 27, 31};
        e0 = sample_edge;
        expect_ev(0, e0 + 3, 0, 5);
        for (int unsigned i = 0; i < 6; i++) expect_ev(0, e0 + 3 + rep_w[i], 0, 5);
        expect_ev(0, e0 + 3 + 35, 1, 5);
        hold_a(1, 5, 3);
        for (int unsigned w = 1; w <= 32; w++) begin
            if (w == 14 || w == 15) step_a(0, 0);
            else                    step_a(1, 5);
            if (w == 15) check("t4_glitch_held", 32'(held_a), 1);
        end
        hold_a(0, 0, 3);
        check("t4_released", 32'(held_a), 0);
        hold_a(0, 0, 2);

        // Reset during release debounce aborts the pending release.
        e0 = sample_edge;
        expect_ev(0, e0 + 3, 0, 5);
        hold_a(1, 5, 5);
        step_a(0, 0);
        rst = 1'b1;
        #1;
        check("t5_valid", 32'(valid_a), 0);
        check("t5_held", 32'(held_a), 0);
        check("t5_release", 32'(release_a), 0);
        check("t5_code", 32'(code_a), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        e0 = sample_edge;
        expect_ev(0, e0 + 3, 0, 7);
        expect_ev(0, e0 + 6, 1, 7);
        hold_a(1, 7, 3);
        check("t5_code7", 32'(code_a), 7);
        hold_a(0, 0, 3);
        hold_a(0, 0, 2);

        // Single-sample debounce, no auto-repeat.
        e0 = sample_edge;
        expect_ev(1, e0 + 1, 0, 3);
        expect_ev(1, e0 + 2, 1, 3);
        step_b(1, 3);
        check("t6_held", 32'(held_b), 1);
        step_b(0, 0);
        check("t6_released", 32'(held_b), 0);
        hold_b(0, 0, 2);
        e0 = sample_edge;
        expect_ev(1, e0 + 1, 0, 3);
        expect_ev(1, e0 + 13, 1, 3);
        hold_b(1, 3, 12);
        hold_b(0, 0, 3);

        check("qa_left", 32'(qa.size()), 0);
        check("qb_left", 32'(qb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
